// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    // Arbiter FSM: IDLE picks a grantee, BURST streams its words.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Default configuration and the widths derived from it.
    localparam int DEF_N_REQ     = 4;
    localparam int DEF_MAX_BURST = 4;
    localparam int GID_W         = $clog2(DEF_N_REQ);
    localparam int CNT_W         = $clog2(DEF_MAX_BURST) + 1;

    // Burst counter width for a given burst limit (one spare bit keeps MAX_BURST=1 legal).
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set req bit at or after ptr, wrapping at N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    // cand[k] is the index visited k-th in the scan, i.e. (ptr + k) mod N.
    logic [W:0]   cand_sum [N];
    logic [W-1:0] cand     [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, ptr} + (W+1)'(gi);
            // ptr is always < N, so one conditional subtraction is a full modulo.
            assign cand[gi] = (cand_sum[gi] >= (W+1)'(N)) ? W'(cand_sum[gi] - (W+1)'(N))
                                                           : cand_sum[gi][W-1:0];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest valid one wins.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                gnt_idx = cand[k];
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one async-FIFO write port.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]              req_last,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic                          busy
);

    localparam int             GW       = $clog2(N_REQ);
    localparam int             CW       = cnt_width(MAX_BURST);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [GW-1:0]  GID_MAX  = GW'(N_REQ - 1);

    arb_state_t              state_reg;
    logic [GW-1:0]           grant_id_reg;
    logic [GW-1:0]           rr_ptr_reg;
    logic [CW-1:0]           cnt_reg;
    logic                    busy_reg;

    logic [GW-1:0]           next_ptr;
    logic [GW-1:0]           pick_idx;
    logic                    pick_any;
    logic                    in_burst;
    logic                    sel_valid;
    logic                    sel_last;
    logic [DATA_WIDTH-1:0]   data_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = wr_en && (grant_id_reg == GW'(gi));
        end
    endgenerate

    rr_pick #(
        .N (N_REQ),
        .W (GW)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_reg),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Write port follows the grantee directly; full blocks the strobe but never the grant.
    assign in_burst  = (state_reg == BURST);
    assign sel_valid = req_valid[grant_id_reg];
    assign sel_last  = req_last[grant_id_reg];
    assign wr_en     = in_burst && sel_valid && !full;
    assign wdata     = data_arr[grant_id_reg];
    assign next_ptr  = (grant_id_reg == GID_MAX) ? '0 : grant_id_reg + 1'b1;
    assign grant_id  = grant_id_reg;
    assign busy      = busy_reg;

    // Grant FSM: pick in IDLE, count writes in BURST, release on last/cap/withdraw.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_reg    <= IDLE;
            grant_id_reg <= '0;
            rr_ptr_reg   <= '0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        grant_id_reg <= pick_idx;
                        cnt_reg      <= '0;
                        state_reg    <= BURST;
                        busy_reg     <= 1'b1;
                    end
                end
                BURST: begin
                    if (!sel_valid) begin
                        // Requester withdrew: drop the grant without a write.
                        state_reg  <= IDLE;
                        rr_ptr_reg <= next_ptr;
                        busy_reg   <= 1'b0;
                    end else if (!full) begin
                        if (sel_last || cnt_reg == CNT_LAST) begin
                            state_reg  <= IDLE;
                            rr_ptr_reg <= next_ptr;
                            busy_reg   <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    // valid & full: stall with grant and count held.
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (N_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    logic               clk;
    logic               wrst;
    logic [3:0]         req_valid;
    logic [31:0]        req_data;
    logic [3:0]         req_last;
    logic [3:0]         req_ready;
    logic               full;
    logic               wr_en;
    logic [7:0]         wdata;
    logic [GID_W-1:0]   grant_id;
    logic               busy;

    int tests = 0;
    int fails = 0;
    int wr_seen = 0;

    fifo_wr_arbiter #(
        .N_REQ      (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .wclk      (clk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .full      (full),
        .wr_en     (wr_en),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic [3:0]       valid;
        logic [31:0]      data;
        logic [3:0]       last;
        logic             full;
        logic             e_wr;
        logic [3:0]       e_rdy;
        logic [7:0]       e_wdata;
        logic [GID_W-1:0] e_gid;
        logic             e_busy;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d,
                         input logic [3:0] l, input logic f);
        wrst      = r;
        req_valid = v;
        req_data  = d;
        req_last  = l;
        full      = f;
    endtask

    // Inputs are set just after posedge; outputs are checked at negedge, then we move past the next posedge.
    task automatic cyc(input string name, input logic ewr, input logic [3:0] erdy,
                       input logic [7:0] edata, input logic [GID_W-1:0] egid, input logic ebusy);
        @(negedge clk);
        tests++;
        if (wr_en) wr_seen++;
        if (wr_en !== ewr || req_ready !== erdy || (ewr && wdata !== edata) ||
            grant_id !== egid || busy !== ebusy) begin
            fails++;
            $display("FAIL %s: got wr_en=%b ready=%b wdata=%h gid=%0d busy=%b, want wr_en=%b ready=%b wdata=%h gid=%0d busy=%b",
                     name, wr_en, req_ready, wdata, grant_id, busy, ewr, erdy, edata, egid, ebusy);
        end else begin
            $display("[TB] ok %s wr_en=%b ready=%b wdata=%h gid=%0d busy=%b",
                     name, wr_en, req_ready, wdata, grant_id, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end else begin
            $display("[TB] ok %s = %0d", name, got);
        end
    endtask

    task automatic reset_cycle();
        drive(1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the run is fixed-length, this only guards against a stuck simulator.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] nseq [4];
        logic [5:0] eseq [4];
        int         words [4];
        logic [3:0] accepted;
        int         sb_err, full_err, oh_err;

        // Reset, fairness (last=1 everywhere) and burst-cap vectors.
        vecs[0]  = '{1'b1, 4'hF, 32'hD3C2B1A0, 4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 4'hF, 32'hD3C2B1A0, 4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 4'hF, 32'hD3C2B1A0, 4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 2'd0, 1'b0};
        vecs[3]  = '{1'b0, 4'hF, 32'hD3C2B1A0, 4'hF, 1'b0, 1'b1, 4'h1, 8'hA0, 2'd0, 1'b1};
        vecs[4]  = '{1'b0, 4'hF, 32'hD3C2B1A0, 4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 2'd0, 1'b0};
        vecs[5]  = '{1'b0, 4'hF, 32'hD3C2B1A0, 4'hF, 1'b0, 1'b1, 4'h2, 8'hB1, 2'd1, 1'b1};
        vecs[6]  = '{1'b0, 4'hF, 32'hD3C2B1A0, 4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 2'd1, 1'b0};
        vecs[7]  = '{1'b0, 4'hF, 32'hD3C2B1A0, 4'hF, 1'b0, 1'b1, 4'h4, 8'hC2, 2'd2, 1'b1};
        vecs[8]  = '{1'b0, 4'hF, 32'hD3C2B1A0, 4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 2'd2, 1'b0};
        vecs[9]  = '{1'b0, 4'hF, 32'hD3C2B1A0, 4'hF, 1'b0, 1'b1, 4'h8, 8'hD3, 2'd3, 1'b1};
        vecs[10] = '{1'b0, 4'hF, 32'hD3C2B1A0, 4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 2'd3, 1'b0};
        vecs[11] = '{1'b0, 4'hF, 32'hD3C2B1A0, 4'hF, 1'b0, 1'b1, 4'h1, 8'hA0, 2'd0, 1'b1};
        vecs[12] = '{1'b1, 4'h0, 32'hD3C2B1A0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 2'd0, 1'b0};
        vecs[13] = '{1'b0, 4'h4, 32'h00A00000, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 2'd0, 1'b0};
        vecs[14] = '{1'b0, 4'h4, 32'h00A00000, 4'h0, 1'b0, 1'b1, 4'h4, 8'hA0, 2'd2, 1'b1};
        vecs[15] = '{1'b0, 4'h4, 32'h00A10000, 4'h0, 1'b0, 1'b1, 4'h4, 8'hA1, 2'd2, 1'b1};
        vecs[16] = '{1'b0, 4'h4, 32'h00A20000, 4'h0, 1'b0, 1'b1, 4'h4, 8'hA2, 2'd2, 1'b1};
        vecs[17] = '{1'b0, 4'h4, 32'h00A30000, 4'h0, 1'b0, 1'b1, 4'h4, 8'hA3, 2'd2, 1'b1};
        vecs[18] = '{1'b0, 4'h4, 32'h00A40000, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 2'd2, 1'b0};
        vecs[19] = '{1'b0, 4'h4, 32'h00A40000, 4'h0, 1'b0, 1'b1, 4'h4, 8'hA4, 2'd2, 1'b1};
        vecs[20] = '{1'b0, 4'h4, 32'h00A50000, 4'h0, 1'b0, 1'b1, 4'h4, 8'hA5, 2'd2, 1'b1};
        vecs[21] = '{1'b0, 4'h0, 32'h00A50000, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 2'd2, 1'b1};
        vecs[22] = '{1'b0, 4'h0, 32'h00A50000, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 2'd2, 1'b0};

        drive(1'b1, 4'h0, 32'h0, 4'h0, 1'b0);
        @(posedge clk);
        #1;

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].rst, vecs[k].valid, vecs[k].data, vecs[k].last, vecs[k].full);
            cyc($sformatf("vec%0d", k), vecs[k].e_wr, vecs[k].e_rdy, vecs[k].e_wdata,
                vecs[k].e_gid, vecs[k].e_busy);
        end

        // Full stall mid-burst of req1: three stalled cycles, burst still totals 4 writes.
        reset_cycle();
        drive(1'b0, 4'b0010, 32'h00001000, 4'h0, 1'b0);
        cyc("stall_grant", 1'b0, 4'h0, 8'h00, 2'd0, 1'b0);
        wr_seen = 0;
        cyc("stall_w0", 1'b1, 4'h2, 8'h10, 2'd1, 1'b1);
        drive(1'b0, 4'b0010, 32'h00001100, 4'h0, 1'b1);
        cyc("stall_f0", 1'b0, 4'h0, 8'h00, 2'd1, 1'b1);
        cyc("stall_f1", 1'b0, 4'h0, 8'h00, 2'd1, 1'b1);
        cyc("stall_f2", 1'b0, 4'h0, 8'h00, 2'd1, 1'b1);
        drive(1'b0, 4'b0010, 32'h00001100, 4'h0, 1'b0);
        cyc("stall_w1", 1'b1, 4'h2, 8'h11, 2'd1, 1'b1);
        drive(1'b0, 4'b0010, 32'h00001200, 4'h0, 1'b0);
        cyc("stall_w2", 1'b1, 4'h2, 8'h12, 2'd1, 1'b1);
        drive(1'b0, 4'b0010, 32'h00001300, 4'h0, 1'b0);
        cyc("stall_w3", 1'b1, 4'h2, 8'h13, 2'd1, 1'b1);
        drive(1'b0, 4'b0010, 32'h00001400, 4'h0, 1'b0);
        cyc("stall_idle", 1'b0, 4'h0, 8'h00, 2'd1, 1'b0);
        expect_int("stall_burst_writes", wr_seen, 4);

        // Withdraw: req3 drops valid after one write, waiting req0 is granted next.
        reset_cycle();
        drive(1'b0, 4'b1000, 32'h3A00000B, 4'h0, 1'b0);
        cyc("wd_grant", 1'b0, 4'h0, 8'h00, 2'd0, 1'b0);
        drive(1'b0, 4'b1001, 32'h3A00000B, 4'h0, 1'b0);
        cyc("wd_write", 1'b1, 4'h8, 8'h3A, 2'd3, 1'b1);
        drive(1'b0, 4'b0001, 32'h3A00000B, 4'h0, 1'b0);
        cyc("wd_drop", 1'b0, 4'h0, 8'h00, 2'd3, 1'b1);
        cyc("wd_idle", 1'b0, 4'h0, 8'h00, 2'd3, 1'b0);
        cyc("wd_req0", 1'b1, 4'h1, 8'h0B, 2'd0, 1'b1);

        // Random scoreboard: per-source order, no write under full, at most one ready.
        reset_cycle();
        drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
        sb_err = 0;
        full_err = 0;
        oh_err = 0;
        for (int i = 0; i < 4; i++) begin
            nseq[i]  = '0;
            eseq[i]  = '0;
            words[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(3) != 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[i*8 +: 8]  = {2'(i), nseq[i]};
                    req_last[i]         = ($urandom_range(2) == 0);
                    nseq[i]             = nseq[i] + 6'd1;
                end
            end
            full = ($urandom_range(3) == 0);
            @(negedge clk);
            accepted = req_ready;
            if (wr_en && full) full_err++;
            if ($countones(req_ready) > 1) oh_err++;
            if (wr_en != (req_ready != 4'h0)) oh_err++;
            for (int i = 0; i < 4; i++) begin
                if (accepted[i]) begin
                    if (!req_valid[i] || wdata !== {2'(i), eseq[i]}) sb_err++;
                    eseq[i] = eseq[i] + 6'd1;
                    words[i]++;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (accepted[i]) req_valid[i] = 1'b0;
            end
        end
        expect_int("sb_order_errors", sb_err, 0);
        expect_int("sb_write_while_full", full_err, 0);
        expect_int("sb_ready_onehot_errors", oh_err, 0);
        for (int i = 0; i < 4; i++) begin
            expect_int($sformatf("sb_src%0d_served", i), int'(words[i] > 100), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
